// File: rtl/uart_rx_fifo_gen2.sv
// UART receiver with 16x oversampling baud generator, majority-vote bit
// sampling, break/framing/parity detection and a first-word-fall-through
// FIFO of {break, framing, parity, data[7:0]} entries.
module uart_rx_fifo_gen2 #(
    parameter int BAUD_W  = 13,
    parameter int ADDR_W  = 4,
    parameter int TO_BITS = 40
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [BAUD_W-1:0] BAUD_VAL,
    input  logic [1:0]        DATA_BITS,
    input  logic              PARITY_EN,
    input  logic              ODD_N_EVEN,
    input  logic              TWO_STOP,
    input  logic              RX,
    input  logic              RD_EN,
    input  logic              CLR_OVERFLOW,
    output logic [7:0]        DATA_OUT,
    output logic              PARITY_ERR,
    output logic              FRAMING_ERR,
    output logic              BREAK,
    output logic              RXRDY,
    output logic [ADDR_W:0]   FIFO_LEVEL,
    output logic              OVERFLOW,
    output logic              TIMEOUT
);
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int TO_TICKS = 16 * TO_BITS;
    localparam int TO_W     = $clog2(TO_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HI
    } state_t;

    logic              r_rx_meta, r_rx_sync;
    logic [BAUD_W-1:0] r_baud_cnt, r_baud_lim;
    logic              w_tick;
    state_t            r_state, w_next;
    logic [3:0]        r_sub;
    logic [2:0]        r_bitcnt, r_samp;
    logic [7:0]        r_shift;
    logic              r_par, r_perr, r_frame, r_allzero;
    logic              w_bit_end, w_maj, w_last_data, w_fe_final;
    logic              w_push, w_start, w_brk;
    logic [10:0]       w_entry;
    logic [10:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr, r_rptr;
    logic [ADDR_W:0]   r_level;
    logic              w_empty, w_full, w_pop, w_wr;
    logic              r_overflow, r_timeout;
    logic [TO_W-1:0]   r_to_cnt;
    logic [10:0]       w_head;

    assign w_tick      = (r_baud_cnt == r_baud_lim);
    assign w_bit_end   = w_tick && (r_sub == 4'd15);
    assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
    assign w_last_data = (r_bitcnt == ({1'b0, DATA_BITS} + 3'd4));
    assign w_fe_final  = r_frame | ~w_maj;
    assign w_empty     = (r_level == {(ADDR_W+1){1'b0}});
    assign w_full      = (r_level == (ADDR_W+1)'(DEPTH));
    assign w_pop       = RD_EN && !w_empty;
    assign w_wr        = w_push && (!w_full || w_pop);
    assign w_head      = r_mem[r_rptr];

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Free-running baud divider; the divisor is re-latched only at a wrap
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_baud_cnt <= {BAUD_W{1'b0}};
            r_baud_lim <= {BAUD_W{1'b0}};
        end else if (w_tick) begin
            r_baud_cnt <= {BAUD_W{1'b0}};
            r_baud_lim <= BAUD_VAL;
        end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
        end
    end

    // Receive FSM state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Receive FSM next-state logic; every bit decision is made at sub-count 15
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_tick && !r_rx_sync) w_next = S_START; else w_next = S_IDLE;
            S_START:   if (w_bit_end) w_next = w_maj ? S_IDLE : S_DATA; else w_next = S_START;
            S_DATA:    if (w_bit_end && w_last_data) w_next = PARITY_EN ? S_PARITY : S_STOP1;
                       else w_next = S_DATA;
            S_PARITY:  if (w_bit_end) w_next = S_STOP1; else w_next = S_PARITY;
            S_STOP1:   if (w_bit_end) begin
                           if (TWO_STOP)        w_next = S_STOP2;
                           else if (w_fe_final) w_next = S_WAIT_HI;
                           else                 w_next = S_IDLE;
                       end else begin
                           w_next = S_STOP1;
                       end
            S_STOP2:   if (w_bit_end) w_next = w_fe_final ? S_WAIT_HI : S_IDLE; else w_next = S_STOP2;
            S_WAIT_HI: if (r_rx_sync) w_next = S_IDLE; else w_next = S_WAIT_HI;
            default:   w_next = S_IDLE;
        endcase
    end

    // Receive FSM outputs: frame start strobe, push strobe and the entry to store
    always_comb begin
        w_start = (r_state == S_IDLE) && w_tick && !r_rx_sync;
        w_push  = 1'b0;
        w_brk   = r_allzero && !w_maj;
        w_entry = 11'd0;
        if (w_bit_end && (((r_state == S_STOP1) && !TWO_STOP) || (r_state == S_STOP2))) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
        if (w_brk) begin
            w_entry = 11'h600;
        end else begin
            w_entry = {1'b0, w_fe_final, r_perr, r_shift};
        end
    end

    // Bit-timing sub-counter, majority samples and per-frame accumulators
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sub     <= 4'd0;
            r_bitcnt  <= 3'd0;
            r_samp    <= 3'b111;
            r_shift   <= 8'd0;
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
            r_frame   <= 1'b0;
            r_allzero <= 1'b0;
        end else if (w_start) begin
            r_sub     <= 4'd0;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'd0;
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
            r_frame   <= 1'b0;
            r_allzero <= 1'b1;
        end else if (w_tick && (r_state != S_IDLE) && (r_state != S_WAIT_HI)) begin
            r_sub <= r_sub + 4'd1;
            if ((r_sub >= 4'd7) && (r_sub <= 4'd9)) begin
                r_samp <= {r_samp[1:0], r_rx_sync};
            end
            if (r_sub == 4'd15) begin
                case (r_state)
                    S_DATA: begin
                        r_shift[r_bitcnt] <= w_maj;
                        r_par             <= r_par ^ w_maj;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                        if (w_maj) r_allzero <= 1'b0;
                    end
                    S_PARITY: begin
                        r_perr <= ((r_par ^ w_maj) != ODD_N_EVEN);
                        if (w_maj) r_allzero <= 1'b0;
                    end
                    S_STOP1: begin
                        r_frame <= ~w_maj;
                        if (w_maj) r_allzero <= 1'b0;
                    end
                    default: r_bitcnt <= r_bitcnt;
                endcase
            end
        end
    end

    // FIFO storage, pointers and fill level
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 11'd0;
            r_wptr  <= {ADDR_W{1'b0}};
            r_rptr  <= {ADDR_W{1'b0}};
            r_level <= {(ADDR_W+1){1'b0}};
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + ADDR_W'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overflow: a dropped frame beats a simultaneous clear
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (CLR_OVERFLOW) begin
            r_overflow <= 1'b0;
        end
    end

    // Idle timeout: counts ticks while data waits and the receiver is idle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_to_cnt  <= {TO_W{1'b0}};
            r_timeout <= 1'b0;
        end else if (w_wr || w_pop || (r_state != S_IDLE) || w_empty) begin
            r_to_cnt  <= {TO_W{1'b0}};
            r_timeout <= 1'b0;
        end else if (w_tick && !r_timeout) begin
            if (r_to_cnt == TO_W'(TO_TICKS - 1)) r_timeout <= 1'b1;
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign RXRDY       = !w_empty;
    assign DATA_OUT    = RXRDY ? w_head[7:0] : 8'd0;
    assign PARITY_ERR  = RXRDY ? w_head[8]   : 1'b0;
    assign FRAMING_ERR = RXRDY ? w_head[9]   : 1'b0;
    assign BREAK       = RXRDY ? w_head[10]  : 1'b0;
    assign FIFO_LEVEL  = r_level;
    assign OVERFLOW    = r_overflow;
    assign TIMEOUT     = r_timeout;
endmodule

// File: tb/tb_uart_rx_fifo_gen2.sv
// Self-checking bench for uart_rx_fifo_gen2 (depth 4, timeout 4 bit times).
module tb_uart_rx_fifo_gen2;
    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [12:0] BAUD_VAL;
    logic [1:0]  DATA_BITS;
    logic        PARITY_EN, ODD_N_EVEN, TWO_STOP, RX, RD_EN, CLR_OVERFLOW;
    logic [7:0]  DATA_OUT;
    logic        PARITY_ERR, FRAMING_ERR, BREAK, RXRDY, OVERFLOW, TIMEOUT;
    logic [2:0]  FIFO_LEVEL;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  ovf_bytes [6];

    uart_rx_fifo_gen2 #(.BAUD_W(13), .ADDR_W(2), .TO_BITS(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .BAUD_VAL(BAUD_VAL), .DATA_BITS(DATA_BITS),
        .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN), .TWO_STOP(TWO_STOP), .RX(RX),
        .RD_EN(RD_EN), .CLR_OVERFLOW(CLR_OVERFLOW), .DATA_OUT(DATA_OUT),
        .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR), .BREAK(BREAK), .RXRDY(RXRDY),
        .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected entry from the frame's bit values and the current configuration
    function automatic logic [10:0] model(input logic [7:0] d, input logic pbit,
                                          input logic s1, input logic s2);
        int n;
        logic [7:0] dm;
        logic ones, perr, fe, brk;
        n = int'(DATA_BITS) + 5;
        dm = 8'd0;
        ones = 1'b0;
        for (int i = 0; i < n; i++) begin
            dm[i] = d[i];
            ones  = ones ^ d[i];
        end
        perr = PARITY_EN && ((ones ^ pbit) != ODD_N_EVEN);
        fe   = !s1 || (TWO_STOP && !s2);
        brk  = (dm == 8'd0) && (!PARITY_EN || !pbit) && !s1 && (!TWO_STOP || !s2);
        return brk ? 11'h600 : {1'b0, fe, perr, dm};
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        logic p;
        p = ODD_N_EVEN;
        for (int i = 0; i < int'(DATA_BITS) + 5; i++) p = p ^ d[i];
        return p;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_cfg(input int baud, input int db, input logic pe, input logic odd, input logic two);
        BAUD_VAL   = 13'(baud);
        DATA_BITS  = 2'(db);
        PARITY_EN  = pe;
        ODD_N_EVEN = odd;
        TWO_STOP   = two;
        wait_clk(40);
    endtask

    // Drive one frame clock by clock; optional noise, latency, clear and timeout probes
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1, input logic s2,
                              input int noise_bit, input bit chk_lat, input bit clr_end, input bit chk_to);
        logic bits [$];
        int nb, cpb, len;
        logic v;
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DATA_BITS) + 5; i++) bits.push_back(d[i]);
        if (PARITY_EN) bits.push_back(pbit);
        bits.push_back(s1);
        if (TWO_STOP) bits.push_back(s2);
        nb  = bits.size();
        cpb = 16 * (int'(BAUD_VAL) + 1);
        len = cpb * (nb + 1) + 80;
        for (int c = 0; c < len; c++) begin
            @(posedge CLK);
            #1;
            if (chk_lat && c == 2 + 16 * nb) chk("latency_before", RXRDY, 32'd0);
            if (chk_lat && c == 3 + 16 * nb) chk("latency_ready", RXRDY, 32'd1);
            if (chk_to && c == 66 + 16 * nb) chk("timeout_before", TIMEOUT, 32'd0);
            if (chk_to && c == 67 + 16 * nb) chk("timeout_set", TIMEOUT, 32'd1);
            v = (c < cpb * nb) ? bits[c / cpb] : 1'b1;
            if (noise_bit >= 0 && c == noise_bit * cpb + 9) v = ~v;
            RX = v;
            CLR_OVERFLOW = clr_end && (c == 2 + 16 * nb);
        end
        CLR_OVERFLOW = 1'b0;
    endtask

    // Compare the FIFO head with an expected entry, then pop it
    task automatic check_pop(input string tag, input logic [10:0] e);
        chk({tag, "_rxrdy"}, RXRDY, 32'd1);
        chk({tag, "_data"}, DATA_OUT, {24'd0, e[7:0]});
        chk({tag, "_perr"}, PARITY_ERR, {31'd0, e[8]});
        chk({tag, "_ferr"}, FRAMING_ERR, {31'd0, e[9]});
        chk({tag, "_break"}, BREAK, {31'd0, e[10]});
        RD_EN = 1'b1;
        wait_clk(1);
        RD_EN = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [10:0] e;
        logic pb, s1, s2;
        RESET_N = 1'b0; RX = 1'b1; RD_EN = 1'b0; CLR_OVERFLOW = 1'b0;
        BAUD_VAL = 13'd0; DATA_BITS = 2'd3; PARITY_EN = 1'b0; ODD_N_EVEN = 1'b0; TWO_STOP = 1'b0;
        #23;
        chk("reset_outputs", {DATA_OUT, PARITY_ERR, FRAMING_ERR, BREAK, RXRDY, FIFO_LEVEL, OVERFLOW, TIMEOUT}, 32'd0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;

        // 8N1 at one tick per clock, exact latency
        set_cfg(0, 3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0);
        chk("t1_level", FIFO_LEVEL, 32'd1);
        check_pop("t1", 11'h0A5);
        chk("t1_empty_rxrdy", RXRDY, 32'd0);
        chk("t1_empty_data", DATA_OUT, 32'd0);

        // 5 bits, odd parity, two stop bits
        set_cfg(3, 0, 1'b1, 1'b1, 1'b1);
        d = 8'h15;
        send_frame(d, ~good_par(d), 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        check_pop("t2_parity", model(d, ~good_par(d), 1'b1, 1'b1));
        d = 8'h0A;
        send_frame(d, good_par(d), 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        check_pop("t2_stop2", model(d, good_par(d), 1'b1, 1'b0));

        // Break: line low for 20 bit times, then a clean frame
        set_cfg(0, 3, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 320; c++) begin
            @(posedge CLK);
            #1;
            if (c == 300) chk("brk_single_entry", FIFO_LEVEL, 32'd1);
            RX = 1'b0;
        end
        RX = 1'b1;
        wait_clk(40);
        chk("brk_after_high", FIFO_LEVEL, 32'd1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        chk("brk_level2", FIFO_LEVEL, 32'd2);
        check_pop("brk", 11'h600);
        check_pop("brk_next", 11'h03C);

        // Start-bit glitch, then single-sample noise on a data bit
        @(posedge CLK);
        #1 RX = 1'b0;
        wait_clk(1);
        RX = 1'b1;
        wait_clk(60);
        chk("glitch_no_entry", FIFO_LEVEL, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        chk("noise_level", FIFO_LEVEL, 32'd1);
        check_pop("noise", 11'h05A);

        // Overflow on a 4-entry FIFO, set beats clear
        for (int k = 0; k < 6; k++) ovf_bytes[k] = 8'($urandom);
        for (int k = 0; k < 5; k++) send_frame(ovf_bytes[k], 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        chk("ovf_level", FIFO_LEVEL, 32'd4);
        chk("ovf_set", OVERFLOW, 32'd1);
        chk("ovf_head", DATA_OUT, {24'd0, ovf_bytes[0]});
        send_frame(ovf_bytes[5], 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0);
        chk("ovf_set_wins", OVERFLOW, 32'd1);
        chk("ovf_level_6th", FIFO_LEVEL, 32'd4);
        CLR_OVERFLOW = 1'b1;
        wait_clk(1);
        CLR_OVERFLOW = 1'b0;
        chk("ovf_cleared", OVERFLOW, 32'd0);
        for (int k = 0; k < 4; k++) check_pop("ovf_pop", {3'b000, ovf_bytes[k]});
        chk("ovf_drained", FIFO_LEVEL, 32'd0);

        // Randomised frames against the reference model
        for (int k = 0; k < 8; k++) begin
            set_cfg($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
            d  = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) begin
                d = 8'd0; pb = 1'b0; s1 = 1'b0; s2 = 1'b0;
            end
            e = model(d, pb, s1, s2);
            send_frame(d, pb, s1, s2, -1, 1'b0, 1'b0, 1'b0);
            check_pop("rand", e);
        end
        chk("rand_drained", FIFO_LEVEL, 32'd0);

        // Idle timeout after 4 bit times, cleared by a pop
        set_cfg(0, 3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b1);
        check_pop("to", 11'h0C3);
        chk("to_cleared", TIMEOUT, 32'd0);

        // Asynchronous reset mid-frame flushes everything
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        chk("rst_pre_level", FIFO_LEVEL, 32'd1);
        RX = 1'b0;
        wait_clk(50);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_async_outputs", {DATA_OUT, PARITY_ERR, FRAMING_ERR, BREAK, RXRDY, FIFO_LEVEL, OVERFLOW, TIMEOUT}, 32'd0);
        RX = 1'b1;
        wait_clk(2);
        RESET_N = 1'b1;
        wait_clk(40);
        chk("rst_still_empty", FIFO_LEVEL, 32'd0);
        send_frame(8'h66, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        check_pop("rst_recover", 11'h066);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
